// File: rtl/hs_pkg.sv
// Shared constants and types for the hs_elastic_fifo valid/ready elastic buffer.
// The constants here describe the default 4-entry build.
package hs_pkg;

  function automatic int clog2_f(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int HS_DEPTH = 4;
  localparam int PTR_W    = clog2_f(HS_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef logic [CNT_W-1:0] hs_cnt_t;

endpackage

// File: rtl/hs_fifo_mem.sv
// Register-array storage for the elastic buffer: one synchronous write port
// and one asynchronous read port.
module hs_fifo_mem
  import hs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = clog2_f(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the data array has no reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hs_elastic_fifo.sv
// DEPTH-entry valid/ready elastic buffer with full throughput and a ready_o
// that never depends on ready_i. Optional macro: HS_FALLTHROUGH_EN (empty bypass).
module hs_elastic_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [DATA_W-1:0]        din,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [DATA_W-1:0]        dout,
  output logic [clog2_f(DEPTH):0]  count,
  output logic                     almost_full
);

  localparam int P_W = clog2_f(DEPTH);
  localparam int C_W = P_W + 1;
  localparam logic [C_W-1:0] FULL_CNT  = C_W'(DEPTH);
  localparam logic [C_W-1:0] AFULL_CNT = C_W'(AFULL_TH);

  logic [P_W-1:0]    r_wr_ptr;
  logic [P_W-1:0]    r_rd_ptr;
  logic [C_W-1:0]    r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_bypass;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_mem_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

`ifdef HS_FALLTHROUGH_EN
  assign w_bypass = w_empty & valid_i & ~rst;
`else
  assign w_bypass = 1'b0;
`endif

  assign ready_o = ~rst & ~w_full;
  // A bypassed beat that is taken downstream in the same cycle is never stored.
  assign w_wr    = valid_i & ready_o & ~(w_bypass & ready_i);
  assign w_rd    = ~w_empty & ready_i;

  assign valid_o     = ~w_empty | w_bypass;
  assign dout        = ~w_empty ? w_mem_rdata : (w_bypass ? din : '0);
  assign count       = r_count;
  assign almost_full = (r_count >= AFULL_CNT);

  hs_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (P_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + P_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + P_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + C_W'(1);
        2'b01:   r_count <= r_count - C_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_elastic_fifo.sv
// Directed self-checking bench for hs_elastic_fifo (DATA_W=8, DEPTH=4, AFULL_TH=3).
// Expectations follow HS_FALLTHROUGH_EN when the bench is built with it defined.
module tb_hs_elastic_fifo;
  import hs_pkg::*;

`ifdef HS_FALLTHROUGH_EN
  localparam bit FT         = 1'b1;
  localparam int LAT        = 0;
  localparam int STREAM_CNT = 0;
`else
  localparam bit FT         = 1'b0;
  localparam int LAT        = 1;
  localparam int STREAM_CNT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] din;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] dout;
  hs_cnt_t    count;
  logic       almost_full;

  int n_checks;
  int n_errors;

  hs_elastic_fifo #(
    .DATA_W   (8),
    .DEPTH    (4),
    .AFULL_TH (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .din         (din),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .dout        (dout),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fill_vals [4];
  logic [7:0] q [$];
  logic [7:0] exp_dout;
  logic       exp_valid;
  logic       v;
  logic       r;
  int         sent;
  int         recv;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; din = 8'h00;
    fill_vals[0] = 8'h11; fill_vals[1] = 8'h22; fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;

    // Power-on reset
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_afull", 32'(almost_full), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rel_ready", 32'(ready_o), 32'd1);

    // T2 fill then drain
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = fill_vals[i];
      tick();
      check("t2_count", 32'(count), 32'(i + 1));
      check("t2_afull", 32'(almost_full), 32'((i + 1) >= 3));
    end
    check("t2_full_ready", 32'(ready_o), 32'd0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_valid", 32'(valid_o), 32'd1);
      check("t2_dout", 32'(dout), 32'(fill_vals[i]));
      tick();
    end
    check("t2_empty_valid", 32'(valid_o), 32'd0);
    check("t2_empty_dout", 32'(dout), 32'd0);
    check("t2_empty_count", 32'(count), 32'd0);

    // T3 streaming at one beat per clock
    valid_i = 1'b1;
    ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      din = 8'(k);
      #1;
      if (k >= LAT) begin
        check("t3_valid", 32'(valid_o), 32'd1);
        check("t3_dout", 32'(dout), 32'(k - LAT));
      end
      tick();
      check("t3_count", 32'(count), 32'(STREAM_CNT));
    end
    valid_i = 1'b0;
`ifndef HS_FALLTHROUGH_EN
    #1;
    check("t3_last_dout", 32'(dout), 32'h0f);
`endif
    tick();
    check("t3_end_count", 32'(count), 32'd0);
    check("t3_end_valid", 32'(valid_o), 32'd0);

    // T4 full with a one-cycle downstream pulse
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 8'h50 + 8'(i);
      tick();
    end
    check("t4_full_count", 32'(count), 32'd4);
    check("t4_full_ready", 32'(ready_o), 32'd0);
    din = 8'h54;
    #1;
    check("t4_head", 32'(dout), 32'h50);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("t4_count_after_pulse", 32'(count), 32'd3);
    check("t4_ready_after_pulse", 32'(ready_o), 32'd1);
    tick();
    check("t4_refill_count", 32'(count), 32'd4);
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_drain", 32'(dout), 32'(8'h51 + 8'(i)));
      tick();
    end
    ready_i = 1'b0;
    check("t4_end_count", 32'(count), 32'd0);

    // T5 random gaps across pointer wrap, checked against a queue model
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
      v = (sent < 10) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 1) == 1);
      valid_i = v;
      ready_i = r;
      din = 8'h60 + 8'(sent);
      #1;
      exp_valid = (q.size() != 0) || (FT && v);
      exp_dout  = (q.size() != 0) ? q[0] : (exp_valid ? din : 8'h00);
      check("t5_valid", 32'(valid_o), 32'(exp_valid));
      check("t5_dout", 32'(dout), 32'(exp_dout));
      check("t5_ready", 32'(ready_o), 32'(q.size() != 4));
      if (v && q.size() != 4) begin
        q.push_back(din);
        sent++;
      end
      if (r && exp_valid) begin
        void'(q.pop_front());
        recv++;
      end
      tick();
      check("t5_count", 32'(count), 32'(q.size()));
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    check("t5_done", 32'(recv), 32'd10);

    // T1 reset in the middle of a burst
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'h70 + 8'(i);
      tick();
    end
    check("t1_pre_count", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    check("t1_count", 32'(count), 32'd0);
    check("t1_valid", 32'(valid_o), 32'd0);
    check("t1_dout", 32'(dout), 32'd0);
    check("t1_ready", 32'(ready_o), 32'd0);
    check("t1_afull", 32'(almost_full), 32'd0);
    tick();
    valid_i = 1'b0;
    rst = 1'b0;
    tick();
    check("t1_rel_ready", 32'(ready_o), 32'd1);
    check("t1_rel_valid", 32'(valid_o), 32'd0);
    check("t1_rel_count", 32'(count), 32'd0);

`ifdef HS_FALLTHROUGH_EN
    // T6 zero-latency bypass when empty
    valid_i = 1'b1;
    ready_i = 1'b1;
    din = 8'hA5;
    #1;
    check("t6_valid", 32'(valid_o), 32'd1);
    check("t6_dout", 32'(dout), 32'hA5);
    tick();
    check("t6_count", 32'(count), 32'd0);
    valid_i = 1'b0;
    ready_i = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
